// File: rtl/ram_param.sv
// ram_param: parametrised single-port synchronous RAM with a registered read
// port, write-first read-during-write, and a post-reset clear state machine
// that zeroes every word before any request is accepted.
//
// Optional feature macro: RAM_PARITY_EN
//   defined   -> each word carries one even-parity bit; perr / perr_inject exist
//   undefined -> plain DATA_W-bit array; perr / perr_inject ports are absent
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   a           word address for read and write
//   wr          write enable
//   Din         write data
//   Rd          read enable
//   Dout        registered read data (holds between reads)
//   Dvalid      one-cycle strobe per accepted read
//   busy        high while in reset or clearing; requests ignored
//   perr        parity error on the current read   (RAM_PARITY_EN only)
//   perr_inject invert stored parity on this write (RAM_PARITY_EN only)
module ram_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] a,
    input  logic              wr,
    input  logic [DATA_W-1:0] Din,
    input  logic              Rd,
    output logic [DATA_W-1:0] Dout,
    output logic              Dvalid,
`ifdef RAM_PARITY_EN
    output logic              busy,
    output logic              perr,
    input  logic              perr_inject
`else
    output logic              busy
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;  // parity bit lives in the MSB
`else
    localparam int MEM_W = DATA_W;
`endif

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    logic [MEM_W-1:0]  mem [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dvalid_q, dvalid_d;
`ifdef RAM_PARITY_EN
    logic              perr_q, perr_d;
`endif

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [MEM_W-1:0]  mem_wd;
    logic [MEM_W-1:0]  rd_word;

    assign rd_word = mem[a];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;
`ifdef RAM_PARITY_EN
        perr_d   = 1'b0;
`endif
        mem_we   = 1'b0;
        mem_wa   = a;
        mem_wd   = '0;

        if (state_q == ST_INIT) begin
            // One word cleared per edge; requests are ignored meanwhile.
            mem_we = 1'b1;
            mem_wa = cnt_q;
            cnt_d  = cnt_q + 1'b1;  // wraps to 0 after the last word
            if (&cnt_q)
                state_d = ST_IDLE;
        end else begin
            if (wr) begin
                mem_we = 1'b1;
`ifdef RAM_PARITY_EN
                mem_wd = {(^Din) ^ perr_inject, Din};
`else
                mem_wd = Din;
`endif
            end
            if (Rd) begin
                dvalid_d = 1'b1;
                if (wr) begin
                    // Write-first: the read sees the data being written.
                    dout_d = Din;
`ifdef RAM_PARITY_EN
                    // Stored parity differs from ^Din exactly when injected.
                    perr_d = perr_inject;
`endif
                end else begin
                    dout_d = rd_word[DATA_W-1:0];
`ifdef RAM_PARITY_EN
                    perr_d = (^rd_word[DATA_W-1:0]) != rd_word[DATA_W];
`endif
                end
            end
        end
    end

    // Storage is deliberately not reset; the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
`ifdef RAM_PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
`ifdef RAM_PARITY_EN
            perr_q   <= perr_d;
`endif
        end
    end

    assign Dout   = dout_q;
    assign Dvalid = dvalid_q;
    assign busy   = (state_q == ST_INIT);
`ifdef RAM_PARITY_EN
    assign perr   = perr_q;
`endif

endmodule

// File: tb/tb_ram_param.sv
// Testbench for ram_param: directed scenarios plus random traffic, checked by
// a scoreboard fed from an array-based reference model of the memory.
module tb_ram_param;

    parameter int DW = 8;
    parameter int AW = 4;
    localparam int DEPTH = 2 ** AW;

    typedef struct packed {
        logic          p;
        logic [DW-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] a = '0;
    logic          wr = 1'b0;
    logic [DW-1:0] din = '0;
    logic          rd = 1'b0;
    logic          inj = 1'b0;
    logic [DW-1:0] dout;
    logic          dvalid;
    logic          busy;
    logic          perr_w;

    ram_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .wr(wr), .Din(din), .Rd(rd),
        .Dout(dout), .Dvalid(dvalid),
`ifdef RAM_PARITY_EN
        .busy(busy), .perr(perr_w), .perr_inject(inj)
`else
        .busy(busy)
`endif
    );
`ifndef RAM_PARITY_EN
    assign perr_w = 1'b0;
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model: contents, and per-word "parity was corrupted" flag.
    logic [DW-1:0] ref_mem [DEPTH];
    logic          ref_bad [DEPTH];
    int            init_left = DEPTH;
    logic          exp_v = 1'b0;
    exp_t          sb[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin
                ref_mem[i] = '0;
                ref_bad[i] = 1'b0;
            end
            sb.delete();
            exp_v = 1'b0;
        end else if (init_left > 0) begin
            init_left = init_left - 1;
            exp_v = 1'b0;
        end else begin
            exp_v = rd;
            if (rd) begin
                exp_t e;
                e.d = wr ? din : ref_mem[a];
`ifdef RAM_PARITY_EN
                e.p = wr ? inj : ref_bad[a];
`else
                e.p = 1'b0;
`endif
                sb.push_back(e);
            end
            if (wr) begin
                ref_mem[a] = din;
                ref_bad[a] = inj;
            end
        end
    end

    task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares every negedge; pops the scoreboard on each Dvalid.
    logic [DW-1:0] hold = '0;
    always @(negedge clk) begin
        if (!rst_n) hold = '0;
        chk("busy", {{DW{1'b0}}, busy}, {{DW{1'b0}}, init_left > 0});
        chk("dvalid", {{DW{1'b0}}, dvalid}, {{DW{1'b0}}, exp_v});
        if (dvalid) begin
            if (sb.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_read: Dvalid with empty scoreboard at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                hold = e.d;
                chk("read_data", {1'b0, dout}, {1'b0, e.d});
                chk("read_perr", {{DW{1'b0}}, perr_w}, {{DW{1'b0}}, e.p});
            end
        end else begin
            chk("hold_data", {1'b0, dout}, {1'b0, hold});
            chk("idle_perr", {{DW{1'b0}}, perr_w}, {(DW+1){1'b0}});
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [AW-1:0] ad,
                       input logic [DW-1:0] d, input logic i);
        wr = w; rd = r; a = ad; din = d;
`ifdef RAM_PARITY_EN
        inj = i;
`else
        inj = 1'b0;
        if (i) inj = 1'b0;
`endif
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0; inj = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, AW'(i), '0, 1'b0);
    endtask

    initial begin
        logic [7:0] k_a5, k_5a, k_11, k_22, k_0f, k_f0, k_ff;
        k_a5 = 8'hA5; k_5a = 8'h5A; k_11 = 8'h11; k_22 = 8'h22;
        k_0f = 8'h0F; k_f0 = 8'hF0; k_ff = 8'hFF;

        // Reset and clear
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dout", {1'b0, dout}, '0);
        chk("reset_busy", {{DW{1'b0}}, busy}, {{DW{1'b0}}, 1'b1});
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, AW'(5), DW'(k_ff), 1'b0);   // ignored during INIT
        cyc(1'b1, 1'b1, AW'(1), DW'(k_ff), 1'b0);   // ignored during INIT
        idle(DEPTH - 2);
        chk("busy_fell", {{DW{1'b0}}, busy}, '0);
        read_all();
        idle(1);

        // Write / back-to-back reads
        cyc(1'b1, 1'b0, AW'(3), DW'(k_a5), 1'b0);
        cyc(1'b1, 1'b0, AW'(15), DW'(k_5a), 1'b0);
        cyc(1'b0, 1'b1, AW'(3), '0, 1'b0);
        cyc(1'b0, 1'b1, AW'(15), '0, 1'b0);
        cyc(1'b0, 1'b1, AW'(3), '0, 1'b0);
        idle(2);

        // Read-during-write
        cyc(1'b1, 1'b0, AW'(7), DW'(k_11), 1'b0);
        cyc(1'b1, 1'b1, AW'(7), DW'(k_22), 1'b0);
        cyc(1'b0, 1'b1, AW'(7), '0, 1'b0);
        idle(1);

        // Parity injection, normal write, and injected bypass read
        cyc(1'b1, 1'b0, AW'(2), DW'(k_0f), 1'b1);
        cyc(1'b1, 1'b0, AW'(4), DW'(k_f0), 1'b0);
        cyc(1'b0, 1'b1, AW'(2), '0, 1'b0);
        cyc(1'b0, 1'b1, AW'(4), '0, 1'b0);
        cyc(1'b1, 1'b1, AW'(9), DW'(k_5a), 1'b1);
        idle(1);

        // Random traffic
        for (int n = 0; n < 400; n++)
            cyc(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom),
                ($urandom_range(0, 7) == 0));
        idle(1);

        // Reset with a read pending between edges
        cyc(1'b1, 1'b0, AW'(3), DW'(k_a5), 1'b0);
        cyc(1'b0, 1'b1, AW'(3), '0, 1'b0);
        rd = 1'b1; a = AW'(3);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_dout", {1'b0, dout}, '0);
        chk("midrst_dvalid", {{DW{1'b0}}, dvalid}, '0);
        chk("midrst_busy", {{DW{1'b0}}, busy}, {{DW{1'b0}}, 1'b1});
        @(posedge clk); #1;
        rd = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Requests during the clear, then a second reset mid-INIT
        for (int n = 0; n < DEPTH / 2; n++)
            cyc(1'($urandom), 1'b1, AW'($urandom), DW'($urandom), 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(DEPTH);
        read_all();
        idle(2);

        chk("sb_empty", (DW+1)'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
